lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Registered load/store unit that replaces the combinational core-to-bus bridge. It decodes the core address against a parametrised set of slave regions, runs a request/grant handshake, and aligns byte and half-word data in both directions with optional sign extension. Misaligned, unmapped and timed-out accesses are reported as errors. It sits between the core's memory stage and the shared system bus.

## Interface
- `NUM_SLAVES`, 4: number of decoded regions, 1..8; unused `bus_ce_o` bits are tied 0.
- `NOARB_MASK`, 8'h01: bit n = 1 means region n completes without a bus request (the boot ROM).
- `TIMEOUT`, 15: maximum cycles in REQ waiting for `bus_gnt_i` before an error is raised.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `core_req_i` in 1: access request, sampled in IDLE.
- `core_we_i` in 1: 1 = store.
- `core_hb_i` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `core_uns_i` in 1: 1 = zero-extend loads, 0 = sign-extend.
- `core_addr_i` in 32: byte address.
- `core_wdata_i` in 32: store data, LSB-aligned.
- `core_rdata_o` out 32: aligned load data.
- `core_busy_o` out 1: high when not IDLE.
- `core_done_o` out 1: one-cycle completion pulse.
- `core_err_o` out 1: valid with `core_done_o`.
- `slave_rdata_i` in 32*NUM_SLAVES: read data, slave n at bits [32n+31:32n].
- `bus_addr_o` out 32: {8'h00, addr[23:0]}.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_we_o` out 1: store.
- `bus_hb_o` out 2: access size.
- `bus_ce_o` out 8: one-hot region select.
- `bus_req_o` out 1: bus request.
- `bus_gnt_i` in 1: grant; completes the access.

## Operation
- States: IDLE, REQ, RESP.
- **IDLE**
  - On `core_req_i`, latch address, size, write enable, `core_uns_i` and write data.
  - Decode the region: a region matches when addr[31:24] equals the package base [31:24] for that index.
  - Check for an error: no region matches, `hb` = 11, a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
  - On error, go to RESP with err = 1. No bus signal toggles.
  - Otherwise go to REQ.
- **REQ**
  - `bus_ce_o`, `bus_addr_o`, `bus_we_o`, `bus_hb_o` and `bus_wdata_o` are driven from the latched values.
  - `bus_req_o` = 1 unless the region is set in NOARB_MASK.
  - Completion:
    - A NOARB region completes on the first REQ cycle.
    - Any other region completes on the cycle `bus_gnt_i` = 1.
  - On completion, capture the selected slave's data, align it, and go to RESP.
  - A 5-bit wait counter increments each REQ cycle without grant. When it reaches TIMEOUT, go to RESP with err = 1 and drop `bus_req_o`.
- **RESP**
  - `core_done_o` = 1 for one cycle, then return to IDLE.
  - A `core_req_i` present in RESP is ignored. The core re-asserts it in IDLE.
- **Load alignment**
  - Shift right by 8 × addr[1:0].
  - Bytes extend bit 7; halves extend bit 15; both are zero-extended when `uns` = 1.
- **Store replication**
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata as-is.
- On any error, `core_rdata_o` = 0.
- Reset in any state forces IDLE and drops every output immediately; an in-flight access is abandoned.

## Timing
- Reset values: all outputs 0, state IDLE, wait counter 0.
- Bus outputs are registered or decoded from registered state only; there is no combinational path from `core_*` to `bus_*`.
- Latency from request cycle to `core_done_o`:
  - NOARB access: 2 cycles.
  - Arbitrated access: 2 + k cycles, where k = cycles with `bus_gnt_i` = 0 in REQ.
  - Error detected in IDLE: 1 cycle.
  - Timeout: TIMEOUT + 1 cycles.
- `bus_gnt_i` is only honoured in REQ; grant in IDLE or RESP is ignored.
- `core_rdata_o` holds its value from RESP until the next completion.

## Structure
- Package `core_pkg` holds:
  - region base constants UROM_BASE, SRAM_BASE, UART_BASE, ERAM_BASE;
  - the size encodings HB_BYTE, HB_HALF, HB_WORD;
  - the state enum.
- One sub-module, `lsu_align`: a combinational load extractor/sign-extender and store replicator, reused by the bench model.

## Test plan
- Word load at 0x0000_0010 (ROM, NOARB), slave0 data 0xDEADBEEF → `bus_req_o` stays 0; `core_done_o` 2 cycles after request; `core_rdata_o` = 0xDEADBEEF; err 0.
- Signed byte load at SRAM_BASE+3, grant after 3 cycles, data 0x80112233 → `core_rdata_o` = 0xFFFFFF80. Repeat with `uns` = 1 → 0x00000080.
- Half store of 0x0000ABCD to SRAM_BASE+2 → `bus_wdata_o` = 0xABCDABCD, `bus_hb_o` = 01, `bus_we_o` = 1, `bus_ce_o` = 8'h02 until grant.
- Word access at SRAM_BASE+1, and access to 0x7F00_0000 → err = 1 one cycle after request; `bus_ce_o` and `bus_req_o` never assert.
- UART load with `bus_gnt_i` held 0 → `bus_req_o` high for 15 cycles; done with err = 1 at cycle 16; `core_rdata_o` = 0.
- `rst_i` asserted in REQ mid-wait → `bus_req_o` and `bus_ce_o` drop in the same cycle, with no `core_done_o`. After release, a new access completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the load/store unit.
//   - Slave region base addresses (only bits [31:24] take part in decoding).
//   - Access size encodings used on core_hb_i / bus_hb_o.
//   - LSU controller state type.
package core_pkg;

  localparam logic [31:0] UROM_BASE = 32'h0000_0000;
  localparam logic [31:0] SRAM_BASE = 32'h1000_0000;
  localparam logic [31:0] UART_BASE = 32'h2000_0000;
  localparam logic [31:0] ERAM_BASE = 32'h8000_0000;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Address tag (bits [31:24]) of region idx. Indices 4..7 are spare regions
  // that only decode when NUM_SLAVES is raised above 4.
  function automatic logic [7:0] region_tag(input logic [2:0] idx);
    logic [7:0] tag;
    case (idx)
      3'd0:    tag = UROM_BASE[31:24];
      3'd1:    tag = SRAM_BASE[31:24];
      3'd2:    tag = UART_BASE[31:24];
      3'd3:    tag = ERAM_BASE[31:24];
      3'd4:    tag = 8'h90;
      3'd5:    tag = 8'hA0;
      3'd6:    tag = 8'hB0;
      default: tag = 8'hC0;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment for the load/store unit.
//   hb_i      : access size (HB_BYTE / HB_HALF / HB_WORD)
//   uns_i     : 1 = zero-extend loads, 0 = sign-extend
//   off_i     : byte offset addr[1:0]
//   ld_raw_i  : raw 32-bit slave read word
//   ld_data_o : load data shifted down to bit 0 and extended
//   st_raw_i  : LSB-aligned store data from the core
//   st_data_o : store data replicated across all byte lanes
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  hb_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_raw_i,
  output logic [31:0] st_data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = ld_raw_i >> {off_i, 3'b000};
    case (hb_i)
      HB_BYTE: ld_data_o = uns_i ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      HB_HALF: ld_data_o = uns_i ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

  always_comb begin
    case (hb_i)
      HB_BYTE: st_data_o = {4{st_raw_i[7:0]}};
      HB_HALF: st_data_o = {2{st_raw_i[15:0]}};
      default: st_data_o = st_raw_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: registered load/store unit between the core memory stage and the
// shared system bus.
//   Parameters: NUM_SLAVES (1..8 decoded regions), NOARB_MASK (regions that
//   complete without a bus request), TIMEOUT (grant wait limit in REQ).
//   Core side : core_req_i/we/hb/uns/addr/wdata in; core_rdata_o, core_busy_o,
//               core_done_o (one-cycle pulse), core_err_o (valid with done).
//   Bus side  : bus_addr/wdata/we/hb/ce/req out, bus_gnt_i in,
//               slave_rdata_i (slave n at [32n+31:32n]).
//   Clock clk_i rising edge; rst_i asynchronous, active-high.
module lsu_ctrl
  import core_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [7:0]  NOARB_MASK = 8'h01,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      core_req_i,
  input  logic                      core_we_i,
  input  logic [1:0]                core_hb_i,
  input  logic                      core_uns_i,
  input  logic [31:0]               core_addr_i,
  input  logic [31:0]               core_wdata_i,
  output logic [31:0]               core_rdata_o,
  output logic                      core_busy_o,
  output logic                      core_done_o,
  output logic                      core_err_o,
  input  logic [32*NUM_SLAVES-1:0]  slave_rdata_i,
  output logic [31:0]               bus_addr_o,
  output logic [31:0]               bus_wdata_o,
  output logic                      bus_we_o,
  output logic [1:0]                bus_hb_o,
  output logic [7:0]                bus_ce_o,
  output logic                      bus_req_o,
  input  logic                      bus_gnt_i
);

  localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  hb_q, hb_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  idx_q, idx_d;
  logic        noarb_q, noarb_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        hit;
  logic [2:0]  hit_idx;
  logic        acc_err;
  logic [31:0] sel_rdata;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [4:0]  cnt_inc;
  logic        in_req;

  // Region decode and access legality, evaluated on the live core request.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (core_addr_i[31:24] == region_tag(3'(i))) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
    acc_err = !hit
           || (core_hb_i == 2'b11)
           || (core_hb_i == HB_HALF && core_addr_i[0])
           || (core_hb_i == HB_WORD && core_addr_i[1:0] != 2'b00);
  end

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 3'(i)) sel_rdata = slave_rdata_i[32*i +: 32];
    end
  end

  lsu_align u_align (
    .hb_i      (hb_q),
    .uns_i     (uns_q),
    .off_i     (addr_q[1:0]),
    .ld_raw_i  (sel_rdata),
    .ld_data_o (ld_data),
    .st_raw_i  (wdata_q),
    .st_data_o (st_data)
  );

  assign cnt_inc = cnt_q + 5'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hb_d    = hb_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    noarb_d = noarb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (core_req_i) begin
          addr_d  = core_addr_i[23:0];
          hb_d    = core_hb_i;
          we_d    = core_we_i;
          uns_d   = core_uns_i;
          wdata_d = core_wdata_i;
          idx_d   = hit_idx;
          noarb_d = NOARB_MASK[hit_idx];
          err_d   = acc_err;
          if (acc_err) begin
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Grant wins over a timeout landing in the same cycle.
        if (noarb_q || bus_gnt_i) begin
          rdata_d = ld_data;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      hb_q    <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      noarb_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hb_q    <= hb_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      noarb_q <= noarb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs are decoded from registered state only and are quiet
  // outside REQ, so an access rejected in IDLE never touches the bus.
  assign in_req       = (state_q == ST_REQ);
  assign bus_ce_o     = in_req ? (8'b1 << idx_q) : '0;
  assign bus_req_o    = in_req && !noarb_q;
  assign bus_addr_o   = in_req ? {8'h00, addr_q} : '0;
  assign bus_wdata_o  = in_req ? st_data : '0;
  assign bus_we_o     = in_req && we_q;
  assign bus_hb_o     = in_req ? hb_q : '0;

  assign core_busy_o  = (state_q != ST_IDLE);
  assign core_done_o  = (state_q == ST_RESP);
  assign core_err_o   = core_done_o && err_q;
  assign core_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized self-checking bench for lsu_ctrl against a
// transaction-level reference model (expected latency, bus view and load
// result computed per access from the address map and alignment rules).
module tb_lsu_ctrl;
  import core_pkg::*;

  localparam int NS      = 4;
  localparam int TMO     = 15;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             core_req_i = 1'b0;
  logic             core_we_i = 1'b0;
  logic [1:0]       core_hb_i = '0;
  logic             core_uns_i = 1'b0;
  logic [31:0]      core_addr_i = '0;
  logic [31:0]      core_wdata_i = '0;
  logic [31:0]      core_rdata_o;
  logic             core_busy_o, core_done_o, core_err_o;
  logic [32*NS-1:0] slave_rdata_i = '0;
  logic [31:0]      bus_addr_o, bus_wdata_o;
  logic             bus_we_o;
  logic [1:0]       bus_hb_o;
  logic [7:0]       bus_ce_o;
  logic             bus_req_o;
  logic             bus_gnt_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] hold_rdata = '0;
  bit          hold_valid = 1'b1;
  logic [31:0] bases [4];

  lsu_ctrl #(
    .NUM_SLAVES (NS),
    .NOARB_MASK (8'h01),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .core_req_i    (core_req_i),
    .core_we_i     (core_we_i),
    .core_hb_i     (core_hb_i),
    .core_uns_i    (core_uns_i),
    .core_addr_i   (core_addr_i),
    .core_wdata_i  (core_wdata_i),
    .core_rdata_o  (core_rdata_o),
    .core_busy_o   (core_busy_o),
    .core_done_o   (core_done_o),
    .core_err_o    (core_err_o),
    .slave_rdata_i (slave_rdata_i),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_we_o      (bus_we_o),
    .bus_hb_o      (bus_hb_o),
    .bus_ce_o      (bus_ce_o),
    .bus_req_o     (bus_req_o),
    .bus_gnt_i     (bus_gnt_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int region_of(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] b;
      b = bases[i];
      if (a[31:24] == b[31:24]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] hb,
                                             input logic uns, input logic [1:0] off);
    logic [31:0] sh;
    sh = raw >> (8 * int'(off));
    if (hb == 2'b00) begin
      if (!uns && sh[7])  return sh | 32'hFFFF_FF00;
      return sh & 32'h0000_00FF;
    end
    if (hb == 2'b01) begin
      if (!uns && sh[15]) return sh | 32'hFFFF_0000;
      return sh & 32'h0000_FFFF;
    end
    return raw;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] hb);
    if (hb == 2'b00) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    if (hb == 2'b01) return {w[15:0], w[15:0]};
    return w;
  endfunction

  task automatic rand_slaves();
    for (int i = 0; i < NS; i++) slave_rdata_i[32*i +: 32] = $urandom;
  endtask

  // One complete access. gdly = number of no-grant REQ cycles before grant.
  task automatic run_access(input logic we, input logic [1:0] hb, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input int gdly);
    int          reg_n, done_n;
    bit          err, noarb, tmo;
    logic [31:0] exp_rd, raw;
    reg_n = region_of(addr);
    err   = (reg_n < 0) || (hb == 2'b11) || (hb == 2'b01 && addr[0]) ||
            (hb == 2'b10 && addr[1:0] != 2'b00);
    noarb = (reg_n == 0);
    tmo   = !err && !noarb && (gdly >= TMO);
    if (err)       done_n = 1;
    else if (noarb) done_n = 2;
    else if (tmo)  done_n = TMO + 1;
    else           done_n = 2 + gdly;
    raw = (reg_n >= 0) ? slave_rdata_i[32*reg_n +: 32] : 32'h0;
    exp_rd = (err || tmo) ? 32'h0 : model_load(raw, hb, uns, addr[1:0]);

    @(negedge clk_i);
    core_req_i   = 1'b1;
    core_we_i    = we;
    core_hb_i    = hb;
    core_uns_i   = uns;
    core_addr_i  = addr;
    core_wdata_i = wdata;
    bus_gnt_i    = 1'($urandom);   // ignored while IDLE

    for (int n = 1; n <= done_n + 1; n++) begin
      @(negedge clk_i);
      check_eq("done", 32'(core_done_o), 32'(n == done_n));
      check_eq("busy", 32'(core_busy_o), 32'(n <= done_n));
      if (n < done_n) begin
        check_eq("bus_ce",    32'(bus_ce_o), 32'(8'h01 << reg_n));
        check_eq("bus_req",   32'(bus_req_o), 32'(!noarb));
        check_eq("bus_addr",  bus_addr_o, {8'h00, addr[23:0]});
        check_eq("bus_we",    32'(bus_we_o), 32'(we));
        check_eq("bus_hb",    32'(bus_hb_o), 32'(hb));
        check_eq("bus_wdata", bus_wdata_o, model_store(wdata, hb));
      end else begin
        check_eq("bus_ce_off",  32'(bus_ce_o), 32'h0);
        check_eq("bus_req_off", 32'(bus_req_o), 32'h0);
        if (err) begin
          check_eq("err_bus_addr",  bus_addr_o, 32'h0);
          check_eq("err_bus_wdata", bus_wdata_o, 32'h0);
          check_eq("err_bus_we",    32'(bus_we_o), 32'h0);
        end
      end
      if (n == done_n) begin
        check_eq("err", 32'(core_err_o), 32'(err || tmo));
        if (!we || err || tmo) check_eq("rdata", core_rdata_o, exp_rd);
      end
      if (n == done_n + 1 && hold_valid) check_eq("rdata_hold", core_rdata_o, hold_rdata);
      if (n == done_n) begin
        hold_valid = !we || err || tmo;
        hold_rdata = exp_rd;
      end

      // Inputs for the next cycle; core fields change to show they were latched.
      core_req_i   = (n == done_n) ? 1'($urandom) : 1'b0;  // ignored in RESP
      core_addr_i  = $urandom;
      core_wdata_i = $urandom;
      core_hb_i    = 2'($urandom);
      core_we_i    = 1'($urandom);
      if (n >= done_n)      bus_gnt_i = (n == done_n) ? 1'($urandom) : 1'b0;
      else if (noarb)       bus_gnt_i = 1'($urandom);
      else                  bus_gnt_i = (n == gdly + 1);
    end
    core_req_i = 1'b0;
    bus_gnt_i  = 1'b0;
  endtask

  initial begin
    bases[0] = UROM_BASE;
    bases[1] = SRAM_BASE;
    bases[2] = UART_BASE;
    bases[3] = ERAM_BASE;

    #3;
    check_eq("rst_rdata", core_rdata_o, 32'h0);
    check_eq("rst_busy",  32'(core_busy_o), 32'h0);
    check_eq("rst_done",  32'(core_done_o), 32'h0);
    check_eq("rst_err",   32'(core_err_o), 32'h0);
    check_eq("rst_ce",    32'(bus_ce_o), 32'h0);
    check_eq("rst_req",   32'(bus_req_o), 32'h0);
    check_eq("rst_addr",  bus_addr_o, 32'h0);
    check_eq("rst_wdata", bus_wdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases
    rand_slaves();
    slave_rdata_i[31:0] = 32'hDEAD_BEEF;
    run_access(1'b0, HB_WORD, 1'b0, 32'h0000_0010, 32'h0, 3);
    rand_slaves();
    slave_rdata_i[63:32] = 32'h8011_2233;
    run_access(1'b0, HB_BYTE, 1'b0, SRAM_BASE + 32'd3, 32'h0, 3);
    run_access(1'b0, HB_BYTE, 1'b1, SRAM_BASE + 32'd3, 32'h0, 3);
    run_access(1'b1, HB_HALF, 1'b0, SRAM_BASE + 32'd2, 32'h0000_ABCD, 2);
    run_access(1'b0, HB_WORD, 1'b0, SRAM_BASE + 32'd1, 32'h0, 0);
    run_access(1'b0, HB_WORD, 1'b0, 32'h7F00_0000, 32'h0, 0);
    run_access(1'b0, HB_WORD, 1'b0, UART_BASE + 32'd4, 32'h0, 100);
    run_access(1'b0, HB_WORD, 1'b0, UART_BASE + 32'd8, 32'h0, TMO - 1);
    run_access(1'b0, HB_HALF, 1'b0, ERAM_BASE + 32'd2, 32'h0, 0);

    // Reset in REQ while waiting for grant
    rand_slaves();
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_hb_i   = HB_WORD;
    core_addr_i = UART_BASE;
    @(negedge clk_i);
    core_req_i = 1'b0;
    @(negedge clk_i);
    check_eq("pre_rst_req", 32'(bus_req_o), 32'h1);
    check_eq("pre_rst_ce",  32'(bus_ce_o), 32'h4);
    #2 rst_i = 1'b1;
    #1;
    check_eq("rst_mid_req",  32'(bus_req_o), 32'h0);
    check_eq("rst_mid_ce",   32'(bus_ce_o), 32'h0);
    check_eq("rst_mid_done", 32'(core_done_o), 32'h0);
    check_eq("rst_mid_busy", 32'(core_busy_o), 32'h0);
    @(negedge clk_i);
    check_eq("rst_hold_done", 32'(core_done_o), 32'h0);
    rst_i = 1'b0;
    hold_valid = 1'b1;
    hold_rdata = 32'h0;
    run_access(1'b0, HB_HALF, 1'b1, SRAM_BASE + 32'd2, 32'h0, 1);

    // Randomized accesses
    for (int t = 0; t < 300; t++) begin
      int          kind, gd;
      logic [31:0] a;
      logic [1:0]  hb;
      rand_slaves();
      kind = $urandom_range(0, 9);
      a = $urandom;
      if (kind < 9) begin
        a[31:24] = bases[kind % 4][31:24];
      end else if (region_of(a) >= 0) begin
        a[31:24] = 8'h7F;
      end
      hb = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) begin
        if (hb == HB_HALF) a[0] = 1'b0;
        if (hb == HB_WORD) a[1:0] = 2'b00;
      end
      gd = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 5);
      run_access(1'($urandom), hb, 1'($urandom), a, $urandom, gd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
